mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Sequences one load or store per request between the CPU control path and a word-wide memory with a req/ack handshake.
- Handles byte/halfword/word sizing, lane steering and sign/zero extension.
- Flags misaligned accesses and memory timeouts.
- On a successful load, presents the extended result with a one-cycle write strobe directly to the memory data register stage (data input and write-enable of the MDR).

Parameters:
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before error (1..255, counter 8 bits)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clock clk
start  input  1  request strobe, sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 half, 10 word, 11 reserved (error)
sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend
addr  input  ADDR_WIDTH  byte address
wdata  input  32  store data, right-justified
busy  output  1  high in ACCESS and DONE
done  output  1  one-cycle completion pulse
error  output  1  valid with done; misaligned/reserved size/timeout
mem_req  output  1  memory request, held until ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-steered store data
mem_rdata  input  32  read data, valid when mem_ack
mem_ack  input  1  memory completion, one cycle
mdr_write  output  1  write strobe to MDR stage
mdr_data  output  32  extended load result

Behaviour:
- All outputs registered. Reset: state IDLE, all outputs 0, timeout counter 0. Reset mid-transaction aborts immediately (mem_req low asynchronously); no done is produced.
- States: IDLE, ACCESS, DONE.
- IDLE: start=1 latches we/size/sign_ext/addr/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> DONE with error=1; no mem_req is issued.
  - Otherwise -> ACCESS with mem_req=1, mem_we, mem_addr, mem_be, mem_wdata driven and the counter cleared.
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable.
  - mem_ack=1 -> DONE; mem_req drops on the same edge. For a load, the steered, extended rdata is captured into mdr_data.
  - No ack -> counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack -> DONE with error=1, mem_req drops, mdr_data unchanged.
- DONE (exactly one cycle): done=1, error as determined; mdr_write=1 only for a successful load -> IDLE.
- Strobe timing: done, error and mdr_write are 1 only in the DONE cycle, 0 otherwise. mdr_data holds its value until the next successful load.
- start while busy is ignored (not queued). mem_ack outside ACCESS is ignored.
- Latency: start sampled at edge N -> mem_req high from N; ack in that cycle -> DONE cycle after edge N+1. Minimum 2 cycles start-to-done.
- Store byte: mem_be = 0001<<addr[1:0]; mem_wdata = wdata[7:0] replicated x4.
- Store half: mem_be = 0011<<(2*addr[1]); mem_wdata = wdata[15:0] replicated x2.
- Store word: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_be per size as for stores, mem_we=0.
  - Byte: rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
  - Extension to 32 bits per sign_ext; word loads are passed unchanged.

Test Plan:
- Word load addr=0x100, ack 3 cycles after mem_req, rdata=0xDEADBEEF -> mem_addr=0x100, be=1111; done+mdr_write one cycle, mdr_data=0xDEADBEEF, error=0.
- Byte load addr=0x203, rdata=0x80112233, sign_ext=1 then 0 -> mdr_data=0xFFFFFF80 then 0x00000080; mem_addr=0x200, be=1000.
- Half store addr=0x302, wdata=0x1234ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD; done=1, mdr_write=0.
- Half load addr=0x101 -> no mem_req ever, done+error in 2nd cycle after start, mdr_data unchanged; size=11 same result.
- No ack, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, then done+error, mdr_write=0; late ack ignored.
- Assert start during ACCESS (ignored); assert reset during ACCESS -> mem_req/busy 0 immediately, no done; next request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single load/store sequencer with lane steering, extension and timeout
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  mdr_write,
    output logic [31:0]           mdr_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Last counter value tolerated before the access is declared dead.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sext;
    logic [1:0]  lat_off;

    logic        bad_req;
    logic [3:0]  be_calc;
    logic [31:0] wd_calc;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    // Decode the incoming request: alignment check, byte enables and replicated store data.
    always_comb begin
        bad_req = 1'b0;
        be_calc = 4'b0000;
        wd_calc = wdata;
        case (size)
            2'b00: begin
                be_calc = 4'b0001 << addr[1:0];
                wd_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc = 4'b0011 << {addr[1], 1'b0};
                wd_calc = {2{wdata[15:0]}};
                bad_req = addr[0];
            end
            2'b10: begin
                be_calc = 4'b1111;
                bad_req = (addr[1:0] != 2'b00);
            end
            default: begin
                bad_req = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits.
    always_comb begin
        rd_byte  = 8'h00;
        rd_half  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (lat_off)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        case (lat_size)
            2'b00:   load_ext = {{24{lat_sext & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{lat_sext & rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Sequencer: IDLE accepts a request, ACCESS waits for ack or timeout, DONE pulses the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_sext  <= 1'b0;
            lat_off   <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            mdr_write <= 1'b0;
            mdr_data  <= 32'h0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            mdr_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_we   <= we;
                        lat_size <= size;
                        lat_sext <= sign_ext;
                        lat_off  <= addr[1:0];
                        busy     <= 1'b1;
                        if (bad_req) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state     <= S_ACCESS;
                            cnt       <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= be_calc;
                            mem_wdata <= wd_calc;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!lat_we) begin
                            mdr_data  <= load_ext;
                            mdr_write <= 1'b1;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mdr_write;
    logic [31:0] mdr_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mdr_write (mdr_write),
        .mdr_data  (mdr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present a request for one cycle; returns at the negedge after it was sampled.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait n cycles in ACCESS, then ack for one cycle; returns in the DONE cycle.
    task automatic ack_after(input int n, input logic [31:0] rd);
        repeat (n) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_mdr", mdr_data, 32'h0);
        reset = 1'b0;

        // word load, ack three cycles after mem_req rises
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check("wl_req", {31'h0, mem_req}, 32'h1);
        check("wl_addr", mem_addr, 32'h100);
        check("wl_be", {28'h0, mem_be}, 32'hF);
        check("wl_we", {31'h0, mem_we}, 32'h0);
        check("wl_busy", {31'h0, busy}, 32'h1);
        check("wl_nodone", {31'h0, done}, 32'h0);
        ack_after(2, 32'hDEADBEEF);
        check("wl_done", {31'h0, done}, 32'h1);
        check("wl_mdrw", {31'h0, mdr_write}, 32'h1);
        check("wl_err", {31'h0, error}, 32'h0);
        check("wl_mdr", mdr_data, 32'hDEADBEEF);
        check("wl_req_off", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        check("wl_done_pulse", {31'h0, done}, 32'h0);
        check("wl_mdrw_pulse", {31'h0, mdr_write}, 32'h0);
        check("wl_idle_busy", {31'h0, busy}, 32'h0);
        check("wl_mdr_hold", mdr_data, 32'hDEADBEEF);

        // byte load lane 3, signed then unsigned
        issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        check("bl_addr", mem_addr, 32'h200);
        check("bl_be", {28'h0, mem_be}, 32'h8);
        ack_after(0, 32'h80112233);
        check("bl_sx_done", {31'h0, done}, 32'h1);
        check("bl_sx_mdr", mdr_data, 32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
        ack_after(1, 32'h80112233);
        check("bl_zx_mdr", mdr_data, 32'h00000080);

        // half store upper lane
        issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD);
        check("hs_we", {31'h0, mem_we}, 32'h1);
        check("hs_be", {28'h0, mem_be}, 32'hC);
        check("hs_wdata", mem_wdata, 32'hABCDABCD);
        check("hs_addr", mem_addr, 32'h300);
        ack_after(1, 32'h0);
        check("hs_done", {31'h0, done}, 32'h1);
        check("hs_mdrw", {31'h0, mdr_write}, 32'h0);
        check("hs_err", {31'h0, error}, 32'h0);
        check("hs_mdr_hold", mdr_data, 32'h00000080);

        // byte store lane 1
        issue(1'b1, 2'b00, 1'b0, 32'h001, 32'h00000055);
        check("bs_be", {28'h0, mem_be}, 32'h2);
        check("bs_wdata", mem_wdata, 32'h55555555);
        ack_after(0, 32'h0);

        // signed half load from upper lane
        issue(1'b0, 2'b01, 1'b1, 32'h002, 32'h0);
        check("hl_be", {28'h0, mem_be}, 32'hC);
        ack_after(0, 32'h80017FFF);
        check("hl_mdr", mdr_data, 32'hFFFF8001);

        // misaligned half, reserved size, misaligned word: no memory traffic
        issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
        check("mis_h_done", {31'h0, done}, 32'h1);
        check("mis_h_err", {31'h0, error}, 32'h1);
        check("mis_h_req", {31'h0, mem_req}, 32'h0);
        check("mis_h_mdrw", {31'h0, mdr_write}, 32'h0);
        check("mis_h_mdr", mdr_data, 32'hFFFF8001);
        issue(1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
        check("rsv_done", {31'h0, done}, 32'h1);
        check("rsv_err", {31'h0, error}, 32'h1);
        check("rsv_req", {31'h0, mem_req}, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
        check("mis_w_err", {31'h0, error}, 32'h1);
        check("mis_w_req", {31'h0, mem_req}, 32'h0);

        // timeout with TIMEOUT_CYCLES = 4
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, 32'd4);
        check("to_done", {31'h0, done}, 32'h1);
        check("to_err", {31'h0, error}, 32'h1);
        check("to_mdrw", {31'h0, mdr_write}, 32'h0);
        check("to_mdr", mdr_data, 32'hFFFF8001);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_done", {31'h0, done}, 32'h0);
        check("late_ack_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        check("late_ack_done2", {31'h0, done}, 32'h0);
        check("late_ack_mdr", mdr_data, 32'hFFFF8001);

        // start while busy is ignored
        issue(1'b1, 2'b10, 1'b0, 32'h500, 32'h11112222);
        start = 1'b1; we = 1'b0; addr = 32'h600;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_addr", mem_addr, 32'h500);
        check("busy_start_we", {31'h0, mem_we}, 32'h1);
        ack_after(0, 32'h0);
        check("busy_start_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("busy_start_noq_req", {31'h0, mem_req}, 32'h0);
        check("busy_start_noq_busy", {31'h0, busy}, 32'h0);

        // reset mid-access aborts immediately, then a normal request
        issue(1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
        check("rst_mid_req_before", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_req", {31'h0, mem_req}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        check("rst_mid_nodone", n, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
        check("post_rst_addr", mem_addr, 32'h800);
        ack_after(1, 32'hCAFEF00D);
        check("post_rst_done", {31'h0, done}, 32'h1);
        check("post_rst_mdr", mdr_data, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
